line_scaler_buf: RTL and testbench



---
 rtl/line_scaler_buf_pkg.sv | 14 +
 rtl/line_scaler_buf_ram.sv | 23 ++
 rtl/line_scaler_buf.sv | 144 ++++++++++++++
 tb/tb_line_scaler_buf.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/line_scaler_buf_pkg.sv
// rtl/line_scaler_buf_pkg.sv - video constants shared by the scaler, timing and PPU blocks
package line_scaler_buf_pkg;

    localparam int VID_PIX_W    = 24;
    localparam int VID_SRC_W    = 256;
    localparam int VID_H_OFFSET = 64;
    localparam logic [VID_PIX_W-1:0] VID_BORDER = 24'h000000;

    // Counter width for a 0..n-1 range; a 1-bit counter still exists when n == 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_scaler_buf_ram.sv
// rtl/line_scaler_buf_ram.sv - two-bank line RAM: write port A, registered read port B
module line_ram_dp #(
    parameter int AW = 9,
    parameter int DW = 24
) (
    input  logic          pclk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    (* ram_style = "block" *) logic [DW-1:0] mem [2**AW];

    always_ff @(posedge pclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/line_scaler_buf.sv
// rtl/line_scaler_buf.sv - ping-pong line buffer with integer H/V replication and border window
module line_scaler_buf
    import line_scaler_buf_pkg::*;
#(
    parameter int PIX_W    = VID_PIX_W,
    parameter int SRC_W    = VID_SRC_W,
    parameter int ADDR_W   = 8,
    parameter int H_SCALE  = 2,
    parameter int V_SCALE  = 2,
    parameter int HCNT_W   = 10,
    parameter int H_OFFSET = VID_H_OFFSET,
    parameter logic [PIX_W-1:0] BORDER = VID_BORDER
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              wr_sol,
    input  logic              wr_valid,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ready,
    input  logic [HCNT_W-1:0] rd_hcnt,
    input  logic              rd_active,
    input  logic              rd_line_end,
    output logic [PIX_W-1:0]  pix_out,
    output logic              pix_de,
    output logic              overrun,
    output logic              underrun,
    input  logic              clr_flags
);

    localparam int HREP_W = cnt_width(H_SCALE);
    localparam int VREP_W = cnt_width(V_SCALE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SRC_W - 1);
    localparam logic [HREP_W-1:0] HREP_MAX  = HREP_W'(H_SCALE - 1);
    localparam logic [VREP_W-1:0] VREP_MAX  = VREP_W'(V_SCALE - 1);
    localparam logic [HCNT_W:0]   WIN_LO    = (HCNT_W+1)'(H_OFFSET);
    localparam logic [HCNT_W:0]   WIN_HI    = (HCNT_W+1)'(H_OFFSET + SRC_W * H_SCALE);

    logic [1:0]        bank_full, full_set, full_clr;
    logic              wr_bank, rd_bank;
    logic [ADDR_W-1:0] wr_addr, waddr_eff, src_addr, cur_src;
    logic [HREP_W-1:0] hrep_cnt, cur_hrep;
    logic [VREP_W-1:0] vrep_cnt;
    logic              wr_en, line_done, in_win, win_start, issue_ok;
    logic              release_rd, repeat_rd, ok_d1, de_d1;
    logic [PIX_W-1:0]  ram_q;

    assign wr_ready  = ~bank_full[wr_bank];
    assign wr_en     = wr_valid & wr_ready;
    assign waddr_eff = wr_sol ? '0 : wr_addr;
    assign line_done = wr_en & (waddr_eff == LAST_ADDR);

    assign in_win    = rd_active & ({1'b0, rd_hcnt} >= WIN_LO) & ({1'b0, rd_hcnt} < WIN_HI);
    assign win_start = ({1'b0, rd_hcnt} == WIN_LO);
    assign cur_src   = win_start ? '0 : src_addr;
    assign cur_hrep  = win_start ? '0 : hrep_cnt;
    assign issue_ok  = in_win & bank_full[rd_bank];

    // Release only when the next line is complete; otherwise hold the current one for another group.
    assign release_rd = rd_line_end & (vrep_cnt == VREP_MAX) & bank_full[~rd_bank];
    assign repeat_rd  = rd_line_end & (vrep_cnt == VREP_MAX) & ~bank_full[~rd_bank] & bank_full[rd_bank];

    always_comb begin
        full_set = '0;
        full_clr = '0;
        full_set[wr_bank] = line_done;
        full_clr[rd_bank] = release_rd;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            bank_full <= '0;
            wr_bank   <= 1'b0;
            wr_addr   <= '0;
            overrun   <= 1'b0;
        end else begin
            bank_full <= (bank_full & ~full_clr) | full_set;
            if (line_done) begin
                wr_bank <= ~wr_bank;
                wr_addr <= '0;
            end else if (wr_en) begin
                wr_addr <= waddr_eff + 1'b1;
            end else if (wr_sol) begin
                wr_addr <= '0;
            end
            if (wr_valid & ~wr_ready) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            rd_bank  <= 1'b0;
            vrep_cnt <= '0;
            src_addr <= '0;
            hrep_cnt <= '0;
            ok_d1    <= 1'b0;
            de_d1    <= 1'b0;
            pix_de   <= 1'b0;
            pix_out  <= BORDER;
            underrun <= 1'b0;
        end else begin
            ok_d1    <= issue_ok;
            de_d1    <= rd_active;
            pix_de   <= de_d1;
            pix_out  <= ok_d1 ? ram_q : BORDER;
            underrun <= repeat_rd;
            if (in_win) begin
                if (cur_hrep == HREP_MAX) begin
                    hrep_cnt <= '0;
                    src_addr <= cur_src + 1'b1;
                end else begin
                    hrep_cnt <= cur_hrep + 1'b1;
                    src_addr <= cur_src;
                end
            end
            if (rd_line_end) begin
                if (vrep_cnt != VREP_MAX) begin
                    vrep_cnt <= vrep_cnt + 1'b1;
                end else if (release_rd) begin
                    rd_bank  <= ~rd_bank;
                    vrep_cnt <= '0;
                end else if (repeat_rd) begin
                    vrep_cnt <= '0;
                end
            end
        end
    end

    line_ram_dp #(
        .AW (ADDR_W + 1),
        .DW (PIX_W)
    ) u_ram (
        .pclk    (pclk),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank, waddr_eff}),
        .wr_data (wr_data),
        .rd_addr ({rd_bank, cur_src}),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_line_scaler_buf.sv
// tb/tb_line_scaler_buf.sv - self-checking bench for line_scaler_buf
module tb_line_scaler_buf;

    localparam int SRC_W    = 256;
    localparam int H_SCALE  = 2;
    localparam int H_OFFSET = 64;
    localparam int H_ACT    = 640;
    localparam int H_TOT    = 648;
    localparam logic [23:0] BORDER = 24'h000000;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_sol = 1'b0;
    logic        wr_valid = 1'b0;
    logic [23:0] wr_data = '0;
    logic        wr_ready;
    logic [9:0]  rd_hcnt = '0;
    logic        rd_active = 1'b0;
    logic        rd_line_end = 1'b0;
    logic [23:0] pix_out;
    logic        pix_de;
    logic        overrun;
    logic        underrun;
    logic        clr_flags = 1'b0;

    int checks = 0;
    int failures = 0;
    int exp_kind = 0;
    int ur_seen = 0;
    logic [23:0] exp_q[$];
    bit act_h1, act_h2;

    always #5 pclk = ~pclk;

    line_scaler_buf #(
        .PIX_W(24), .SRC_W(SRC_W), .ADDR_W(8), .H_SCALE(H_SCALE), .V_SCALE(2),
        .HCNT_W(10), .H_OFFSET(H_OFFSET), .BORDER(BORDER)
    ) dut (
        .pclk(pclk), .rst(rst), .wr_sol(wr_sol), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_hcnt(rd_hcnt), .rd_active(rd_active), .rd_line_end(rd_line_end),
        .pix_out(pix_out), .pix_de(pix_de), .overrun(overrun), .underrun(underrun),
        .clr_flags(clr_flags)
    );

    function automatic logic [23:0] pat(input int k, input int i);
        case (k)
            0:       pat = 24'(i);
            1:       pat = 24'(i * 65793);
            2:       pat = 24'hFF0000 ^ 24'(i * 7);
            3:       pat = 24'(i * 40503 + 12345);
            default: pat = 24'h00AA55 ^ 24'(i);
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0; wr_sol = 1'b0; clr_flags = 1'b0;
        rd_active = 1'b0; rd_line_end = 1'b0; rd_hcnt = '0;
        repeat (2) @(posedge pclk);
        #1 rst = 1'b0;
    endtask

    task automatic write_line(input int kind, input int n, input bit sol);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk); #1;
            wr_valid = 1'b1; wr_data = pat(kind, i); wr_sol = sol && (i == 0);
        end
        @(posedge pclk); #1;
        wr_valid = 1'b0; wr_sol = 1'b0;
    endtask

    // Drives one output line; expected pixels queued at issue, popped as pix_de presents them.
    task automatic run_line(input bit present, input string tag);
        int bad = 0;
        int de_bad = 0;
        logic [23:0] e;
        logic [23:0] first_got = '0;
        logic [23:0] first_exp = '0;
        act_h1 = 1'b0; act_h2 = 1'b0;
        for (int h = 0; h < H_TOT; h++) begin
            @(posedge pclk); #1;
            rd_hcnt = 10'(h); rd_active = (h < H_ACT); rd_line_end = (h == H_TOT - 1);
            if (h < H_ACT) begin
                if (present && h >= H_OFFSET && h < H_OFFSET + SRC_W * H_SCALE)
                    e = pat(exp_kind, (h - H_OFFSET) / H_SCALE);
                else
                    e = BORDER;
                exp_q.push_back(e);
            end
            @(negedge pclk);
            if (pix_de !== act_h2) de_bad++;
            if (pix_de === 1'b1) begin
                if (exp_q.size() == 0) begin
                    bad++;
                end else begin
                    e = exp_q.pop_front();
                    if (pix_out !== e) begin
                        if (bad == 0) begin first_got = pix_out; first_exp = e; end
                        bad++;
                    end
                end
            end
            if (underrun === 1'b1) ur_seen++;
            act_h2 = act_h1; act_h1 = rd_active;
        end
        @(posedge pclk); #1;
        rd_active = 1'b0; rd_line_end = 1'b0; rd_hcnt = '0;
        @(negedge pclk);
        if (underrun === 1'b1) ur_seen++;
        checks++;
        if (bad != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s pixels: %0d wrong, %0d missing, first got %h required %h",
                     tag, bad, exp_q.size(), first_got, first_exp);
        end
        checks++;
        if (de_bad != 0) begin
            failures++;
            $display("FAIL %s pix_de alignment: %0d cycles wrong, required 0", tag, de_bad);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge pclk);
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset wr_ready: got %b required 1", wr_ready); end
        checks++; if (pix_de !== 1'b0) begin failures++; $display("FAIL reset pix_de: got %b required 0", pix_de); end
        checks++; if (pix_out !== BORDER) begin failures++; $display("FAIL reset pix_out: got %h required %h", pix_out, BORDER); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset overrun: got %b required 0", overrun); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset underrun: got %b required 0", underrun); end
        ur_seen = 0;
        for (int l = 0; l < 3; l++) run_line(1'b0, "empty_line");
        checks++; if (ur_seen != 0) begin failures++; $display("FAIL empty underrun count: got %0d required 0", ur_seen); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL empty wr_ready: got %b required 1", wr_ready); end
    endtask

    task automatic test_ramp();
        do_reset();
        write_line(0, SRC_W, 1'b0);
        @(negedge pclk);
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL ramp wr_ready: got %b required 1", wr_ready); end
        exp_kind = 0; ur_seen = 0;
        run_line(1'b1, "ramp_line1");
        run_line(1'b1, "ramp_line2");
        checks++; if (ur_seen != 1) begin failures++; $display("FAIL ramp underrun count: got %0d required 1", ur_seen); end
    endtask

    task automatic test_overrun();
        do_reset();
        write_line(1, SRC_W, 1'b0);
        write_line(2, SRC_W, 1'b0);
        @(negedge pclk);
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL both_full wr_ready: got %b required 0", wr_ready); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL pre_drop overrun: got %b required 0", overrun); end
        @(posedge pclk); #1; wr_valid = 1'b1; wr_data = pat(3, 0);
        @(posedge pclk); #1; wr_valid = 1'b0;
        @(negedge pclk);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL drop overrun: got %b required 1", overrun); end
        repeat (20) @(posedge pclk);
        @(negedge pclk);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL sticky overrun: got %b required 1", overrun); end
        @(posedge pclk); #1; clr_flags = 1'b1; wr_valid = 1'b1;
        @(posedge pclk); #1; clr_flags = 1'b0; wr_valid = 1'b0;
        @(negedge pclk);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL set_beats_clear overrun: got %b required 1", overrun); end
        @(posedge pclk); #1; clr_flags = 1'b1;
        @(posedge pclk); #1; clr_flags = 1'b0;
        @(negedge pclk);
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL clr overrun: got %b required 0", overrun); end
        exp_kind = 1; ur_seen = 0;
        run_line(1'b1, "ovr_lineA1");
        run_line(1'b1, "ovr_lineA2");
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL released wr_ready: got %b required 1", wr_ready); end
        exp_kind = 2;
        run_line(1'b1, "ovr_lineB1");
        run_line(1'b1, "ovr_lineB2");
        checks++; if (ur_seen != 1) begin failures++; $display("FAIL ovr underrun count: got %0d required 1", ur_seen); end
    endtask

    task automatic test_underrun();
        do_reset();
        write_line(3, SRC_W, 1'b0);
        exp_kind = 3; ur_seen = 0;
        run_line(1'b1, "ur_line1");
        run_line(1'b1, "ur_line2");
        checks++; if (ur_seen != 1) begin failures++; $display("FAIL underrun after line2: got %0d required 1", ur_seen); end
        run_line(1'b1, "ur_line3");
        run_line(1'b1, "ur_line4");
        checks++; if (ur_seen != 2) begin failures++; $display("FAIL underrun after line4: got %0d required 2", ur_seen); end
    endtask

    task automatic test_sol();
        do_reset();
        write_line(4, 100, 1'b0);
        @(negedge pclk);
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL partial wr_ready: got %b required 1", wr_ready); end
        write_line(1, SRC_W, 1'b1);
        @(negedge pclk);
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL sol wr_ready: got %b required 1", wr_ready); end
        exp_kind = 1; ur_seen = 0;
        run_line(1'b1, "sol_line1");
        run_line(1'b1, "sol_line2");
        checks++; if (ur_seen != 1) begin failures++; $display("FAIL sol underrun count: got %0d required 1", ur_seen); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_line(2, SRC_W, 1'b0);
        for (int i = 0; i < 200; i++) begin
            @(posedge pclk); #1;
            rd_hcnt = 10'(i); rd_active = 1'b1; wr_valid = 1'b1; wr_data = pat(3, i);
        end
        @(posedge pclk); #1; rst = 1'b1;
        @(posedge pclk); #1; rst = 1'b0; rd_active = 1'b0; wr_valid = 1'b0; rd_hcnt = '0;
        @(negedge pclk);
        checks++; if (pix_de !== 1'b0) begin failures++; $display("FAIL midrst pix_de: got %b required 0", pix_de); end
        checks++; if (pix_out !== BORDER) begin failures++; $display("FAIL midrst pix_out: got %h required %h", pix_out, BORDER); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL midrst wr_ready: got %b required 1", wr_ready); end
        ur_seen = 0;
        run_line(1'b0, "midrst_empty");
        checks++; if (ur_seen != 0) begin failures++; $display("FAIL midrst underrun count: got %0d required 0", ur_seen); end
        write_line(4, SRC_W, 1'b0);
        exp_kind = 4;
        run_line(1'b1, "midrst_line1");
        run_line(1'b1, "midrst_line2");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_overrun();
        test_underrun();
        test_sol();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
